// File: rtl/traffic_phase_sequencer_pkg.sv
// Shared encodings for the intersection controller: phase codes, lamp codes and timer sizing.
package traffic_phase_sequencer_pkg;

   localparam int unsigned PHASE_W = 3;
   localparam int unsigned LAMP_W  = 3;

   localparam logic [PHASE_W-1:0] ST_MAIN_GREEN  = 3'd0;
   localparam logic [PHASE_W-1:0] ST_MAIN_YELLOW = 3'd1;
   localparam logic [PHASE_W-1:0] ST_ALL_RED_1   = 3'd2;
   localparam logic [PHASE_W-1:0] ST_SIDE_GREEN  = 3'd3;
   localparam logic [PHASE_W-1:0] ST_SIDE_YELLOW = 3'd4;
   localparam logic [PHASE_W-1:0] ST_ALL_RED_2   = 3'd5;
   localparam logic [PHASE_W-1:0] ST_FLASH       = 3'd6;

   localparam logic [LAMP_W-1:0] LAMP_RED = 3'b100;
   localparam logic [LAMP_W-1:0] LAMP_YEL = 3'b010;
   localparam logic [LAMP_W-1:0] LAMP_GRN = 3'b001;
   localparam logic [LAMP_W-1:0] LAMP_OFF = 3'b000;

   // Timer width large enough to hold the longest reload value; never below one bit.
   function automatic int unsigned timer_width(input int unsigned a, input int unsigned b,
                                               input int unsigned c, input int unsigned d);
      int unsigned m;
      int unsigned w;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      w = $clog2(m);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/traffic_phase_sequencer_if.sv
// Sensor/strobe inputs and lamp/phase outputs of the intersection controller.
interface traffic_phase_sequencer_if;
   import traffic_phase_sequencer_pkg::*;

   logic               tick;
   logic               side_car;
   logic               ped_req;
   logic               flash_en;
   logic [LAMP_W-1:0]  main_light;
   logic [LAMP_W-1:0]  side_light;
   logic               walk;
   logic [PHASE_W-1:0] phase;
   logic               phase_start;

   modport master (output tick, side_car, ped_req, flash_en,
                   input  main_light, side_light, walk, phase, phase_start);

   modport slave  (input  tick, side_car, ped_req, flash_en,
                   output main_light, side_light, walk, phase, phase_start);

endinterface

// File: rtl/traffic_phase_sequencer_timer.sv
// Reloadable down-counter in tick units; expire flags the tick that finds the count at zero.
module phase_timer #(
   parameter int unsigned CW = 5
) (
   input  logic          clk,
   input  logic          reset_i,
   input  logic          load_i,
   input  logic [CW-1:0] load_val_i,
   input  logic          tick_i,
   output logic          expire_o,
   output logic [CW-1:0] count_o
);

   logic [CW-1:0] count_q;

   // Load wins over reset so the parent can seed the post-reset phase length.
   always_ff @(posedge clk) begin
      if (load_i)                          count_q <= load_val_i;
      else if (reset_i)                    count_q <= '0;
      else if (tick_i && count_q != '0)    count_q <= count_q - CW'(1);
   end

   assign expire_o = tick_i && (count_q == '0);
   assign count_o  = count_q;

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Main/side intersection phase FSM with pedestrian latch, flash override and lamp decode.
module traffic_phase_sequencer
   import traffic_phase_sequencer_pkg::*;
#(
   parameter int unsigned T_MAIN_GREEN = 20,
   parameter int unsigned T_SIDE_GREEN = 10,
   parameter int unsigned T_YELLOW     = 3,
   parameter int unsigned T_ALL_RED    = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   traffic_phase_sequencer_if.slave bus
);

   localparam int unsigned CW = timer_width(T_MAIN_GREEN, T_SIDE_GREEN, T_YELLOW, T_ALL_RED);

   logic [PHASE_W-1:0] state_q, state_d;
   logic               ped_latch_q, ped_latch_d;
   logic               blink_q, blink_d;
   logic               phase_start_q;
   logic               load;
   logic [CW-1:0]      load_val;
   logic               expire;
   logic [CW-1:0]      count;
   logic               demand;
   logic [LAMP_W-1:0]  main_c, side_c;

   phase_timer #(.CW(CW)) u_timer (
      .clk        (clk),
      .reset_i    (reset),
      .load_i     (load),
      .load_val_i (load_val),
      .tick_i     (bus.tick),
      .expire_o   (expire),
      .count_o    (count)
   );

   assign demand = bus.side_car | ped_latch_q | bus.ped_req;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_ALL_RED_2;
         ped_latch_q   <= 1'b0;
         blink_q       <= 1'b0;
         phase_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ped_latch_q   <= ped_latch_d;
         blink_q       <= blink_d;
         phase_start_q <= (state_d != state_q);
      end
   end

   // Next state and timer reload; each reload lands on the same edge as its state change.
   always_comb begin
      state_d  = state_q;
      load     = 1'b0;
      load_val = '0;
      if (reset) begin
         state_d  = ST_ALL_RED_2;
         load     = 1'b1;
         load_val = CW'(T_ALL_RED - 1);
      end else if (bus.flash_en) begin
         state_d = ST_FLASH;
      end else begin
         case (state_q)
            ST_MAIN_GREEN: if (expire && demand) begin
               state_d = ST_MAIN_YELLOW; load = 1'b1; load_val = CW'(T_YELLOW - 1);
            end
            ST_MAIN_YELLOW: if (expire) begin
               state_d = ST_ALL_RED_1;   load = 1'b1; load_val = CW'(T_ALL_RED - 1);
            end
            ST_ALL_RED_1: if (expire) begin
               state_d = ST_SIDE_GREEN;  load = 1'b1; load_val = CW'(T_SIDE_GREEN - 1);
            end
            ST_SIDE_GREEN: if (expire) begin
               state_d = ST_SIDE_YELLOW; load = 1'b1; load_val = CW'(T_YELLOW - 1);
            end
            ST_SIDE_YELLOW: if (expire) begin
               state_d = ST_ALL_RED_2;   load = 1'b1; load_val = CW'(T_ALL_RED - 1);
            end
            ST_ALL_RED_2: if (expire) begin
               state_d = ST_MAIN_GREEN;  load = 1'b1; load_val = CW'(T_MAIN_GREEN - 1);
            end
            default: begin
               state_d = ST_ALL_RED_2;   load = 1'b1; load_val = CW'(T_ALL_RED - 1);
            end
         endcase
      end
   end

   // Entering the walk phase serves the pending request, so the clear beats a same-cycle set.
   always_comb begin
      ped_latch_d = ped_latch_q;
      if (bus.ped_req && state_q != ST_SIDE_GREEN)           ped_latch_d = 1'b1;
      if (state_d == ST_SIDE_GREEN && state_q != ST_SIDE_GREEN) ped_latch_d = 1'b0;
      blink_d = (state_q == ST_FLASH) ? (blink_q ^ bus.tick) : 1'b0;
   end

   always_comb begin
      main_c = LAMP_RED;
      side_c = LAMP_RED;
      case (state_q)
         ST_MAIN_GREEN:  main_c = LAMP_GRN;
         ST_MAIN_YELLOW: main_c = LAMP_YEL;
         ST_SIDE_GREEN:  side_c = LAMP_GRN;
         ST_SIDE_YELLOW: side_c = LAMP_YEL;
         ST_FLASH: begin
            main_c = blink_q ? LAMP_YEL : LAMP_OFF;
            side_c = blink_q ? LAMP_RED : LAMP_OFF;
         end
         default: ;
      endcase
   end

   assign bus.main_light  = main_c;
   assign bus.side_light  = side_c;
   assign bus.walk        = (state_q == ST_SIDE_GREEN);
   assign bus.phase       = state_q;
   assign bus.phase_start = phase_start_q;

   logic unused_count;
   assign unused_count = ^count;

endmodule
